// File: rtl/systolic_operand_sequencer_if.sv
// Operand-load and skewed-stream bundle between the systolic operand sequencer and its host/array.
interface systolic_operand_sequencer_if #(
    parameter int N = 8,
    parameter int S = 4,
    parameter int P = 2
);
    localparam int K  = P * S;
    localparam int KW = $clog2(K);

    logic            wr_en;
    logic            wr_mat;
    logic [KW-1:0]   wr_idx;
    logic [S*N-1:0]  wr_data;
    logic            start;
    logic            abort;
    logic [S*N-1:0]  a_out;
    logic [S*N-1:0]  b_out;
    logic            out_valid;
    logic            acc_clr;
    logic            busy;
    logic            done;

    modport master (
        output wr_en, wr_mat, wr_idx, wr_data, start, abort,
        input  a_out, b_out, out_valid, acc_clr, busy, done
    );

    modport slave (
        input  wr_en, wr_mat, wr_idx, wr_data, start, abort,
        output a_out, b_out, out_valid, acc_clr, busy, done
    );
endinterface

// File: rtl/systolic_operand_sequencer.sv
// Operand store plus triangular-skew stream sequencer for an SxS output-stationary array.
// state | meaning: IDLE waiting for start | FEED streaming c=0..K+S-2 | DRAIN array flush | DONE done pulse
module systolic_operand_sequencer #(
    parameter int N     = 8,
    parameter int S     = 4,
    parameter int P     = 2,
    parameter int DRAIN = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    systolic_operand_sequencer_if.slave   bus
);
    localparam int K    = P * S;
    localparam int KW   = $clog2(K);
    localparam int CLEN = K + S - 1;
    localparam int CMAX = (CLEN + 1 > DRAIN + 1) ? CLEN + 1 : DRAIN + 1;
    localparam int CW   = $clog2(CMAX);
    localparam logic [CW-1:0] C_LAST = CW'(CLEN - 1);
    localparam logic [CW-1:0] D_LOAD = CW'(DRAIN - 1);
    localparam logic [KW:0]   K_LIM  = (KW + 1)'(K);

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [S*N-1:0]  r_a [K];
    logic [S*N-1:0]  r_b [K];
    logic [S*N-1:0]  w_a_eff [K];
    logic [S*N-1:0]  w_b_eff [K];
    logic            w_wr_ok;

    logic [S*N-1:0]  r_a_out, r_b_out, w_a_nxt, w_b_nxt;
    logic            r_valid, r_clr, r_busy, r_done;
    logic            w_valid_nxt, w_clr_nxt, w_busy_nxt, w_done_nxt;

    assign w_wr_ok = bus.wr_en && (r_state == S_IDLE || r_state == S_DONE)
                     && ({1'b0, bus.wr_idx} < K_LIM);

    // Same-edge write forwarding so a run started on the write edge sees the new data.
    always_comb begin
        for (int k = 0; k < K; k++) begin
            w_a_eff[k] = r_a[k];
            w_b_eff[k] = r_b[k];
            if (w_wr_ok && bus.wr_idx == KW'(k)) begin
                if (bus.wr_mat) w_b_eff[k] = bus.wr_data;
                else            w_a_eff[k] = bus.wr_data;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_a_out <= '0;
            r_b_out <= '0;
            r_valid <= 1'b0;
            r_clr   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int k = 0; k < K; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_a_out <= w_a_nxt;
            r_b_out <= w_b_nxt;
            r_valid <= w_valid_nxt;
            r_clr   <= w_clr_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            for (int k = 0; k < K; k++) begin
                r_a[k] <= w_a_eff[k];
                r_b[k] <= w_b_eff[k];
            end
        end
    end

    // FEED counts c upward; DRAIN reuses the counter as a down-counter to zero.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_FEED;
                    w_cnt_nxt   = '0;
                end
            end
            S_FEED: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_LAST) begin
                    if (DRAIN == 0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_DRAIN;
                        w_cnt_nxt   = D_LOAD;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DRAIN: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == '0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_DONE: begin
                w_cnt_nxt   = '0;
                w_state_nxt = bus.start ? S_FEED : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_a_nxt     = '0;
        w_b_nxt     = '0;
        w_valid_nxt = (w_state_nxt == S_FEED);
        w_clr_nxt   = (w_state_nxt == S_FEED) && (w_cnt_nxt == '0);
        w_busy_nxt  = (w_state_nxt == S_FEED) || (w_state_nxt == S_DRAIN);
        w_done_nxt  = (w_state_nxt == S_DONE);
        if (w_state_nxt == S_FEED) begin
            for (int x = 0; x < S; x++) begin
                for (int k = 0; k < K; k++) begin
                    if (int'(w_cnt_nxt) == k + x) begin
                        w_a_nxt[x*N +: N] = w_a_eff[k][x*N +: N];
                        w_b_nxt[x*N +: N] = w_b_eff[k][x*N +: N];
                    end
                end
            end
        end
    end

    assign bus.a_out     = r_a_out;
    assign bus.b_out     = r_b_out;
    assign bus.out_valid = r_valid;
    assign bus.acc_clr   = r_clr;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_systolic_operand_sequencer.sv
// Directed bench for systolic_operand_sequencer with a cycle-index reference model.
module tb_systolic_operand_sequencer;
    localparam int N     = 8;
    localparam int S     = 4;
    localparam int P     = 2;
    localparam int DRAIN = 4;
    localparam int K     = P * S;
    localparam int LAST_FEED = K + S - 2;
    localparam int DONE_C    = K + S + DRAIN - 1;

    logic clk;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_done = 0;

    systolic_operand_sequencer_if #(.N(N), .S(S), .P(P)) bus ();

    systolic_operand_sequencer #(.N(N), .S(S), .P(P), .DRAIN(DRAIN)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: operand matrices plus index c of the current run cycle (-1 = no run).
    logic [N-1:0] ma [S][K];
    logic [N-1:0] mb [K][S];
    int mc = -1;

    task automatic model_clear();
        for (int i = 0; i < S; i++)
            for (int k = 0; k < K; k++) begin
                ma[i][k] = '0;
                mb[k][i] = '0;
            end
        mc = -1;
    endtask

    always @(negedge rst_n) model_clear();

    always @(posedge clk) begin
        if (rst_n) begin
            bit busy_m;
            busy_m = (mc >= 0 && mc < DONE_C);
            if (bus.wr_en && !busy_m && int'(bus.wr_idx) < K) begin
                for (int x = 0; x < S; x++) begin
                    if (bus.wr_mat) mb[bus.wr_idx][x] = bus.wr_data[x*N +: N];
                    else            ma[x][bus.wr_idx] = bus.wr_data[x*N +: N];
                end
            end
            if (busy_m && bus.abort) mc = -1;
            else if (busy_m)         mc = mc + 1;
            else if (bus.start)      mc = 0;
            else                     mc = -1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s c=%0d t=%0t got %h exp %h", nm, mc, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [S*N-1:0] ea, eb;
        bit ev;
        ev = (mc >= 0 && mc <= LAST_FEED);
        ea = '0;
        eb = '0;
        for (int x = 0; x < S; x++) begin
            if (ev && mc - x >= 0 && mc - x < K) begin
                ea[x*N +: N] = ma[x][mc - x];
                eb[x*N +: N] = mb[mc - x][x];
            end
        end
        chk("a_out", 64'(bus.a_out), 64'(ea));
        chk("b_out", 64'(bus.b_out), 64'(eb));
        chk("out_valid", 64'(bus.out_valid), 64'(ev));
        chk("acc_clr", 64'(bus.acc_clr), 64'(mc == 0));
        chk("busy", 64'(bus.busy), 64'(mc >= 0 && mc < DONE_C));
        chk("done", 64'(bus.done), 64'(mc == DONE_C));
        if (bus.done === 1'b1) n_done++;
    end

    task automatic quiet();
        bus.wr_en = 0; bus.wr_mat = 0; bus.wr_idx = '0; bus.wr_data = '0;
        bus.start = 0; bus.abort = 0;
    endtask

    task automatic load_ab();
        for (int k = 0; k < K; k++) begin
            @(negedge clk);
            bus.wr_en = 1; bus.wr_mat = 0; bus.wr_idx = k[2:0];
            for (int i = 0; i < S; i++) bus.wr_data[i*N +: N] = N'(16 * i + k);
            @(negedge clk);
            bus.wr_mat = 1;
            for (int j = 0; j < S; j++) bus.wr_data[j*N +: N] = N'(16 * k + j);
        end
        @(negedge clk);
        quiet();
    endtask

    // Returns at the negedge sampling cycle c = 0.
    task automatic start_pulse();
        @(negedge clk); bus.start = 1;
        @(negedge clk); bus.start = 0;
    endtask

    task automatic wait_done(output int cyc, output int nval);
        cyc = 0; nval = 0;
        while (bus.done !== 1'b1 && cyc < 60) begin
            if (bus.out_valid === 1'b1) nval++;
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", 64'(bus.done), 64'd1);
    endtask

    task automatic chk_zero_outs(input string tag);
        chk({tag, "_a"}, 64'(bus.a_out), 64'd0);
        chk({tag, "_b"}, 64'(bus.b_out), 64'd0);
        chk({tag, "_v"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_clr"}, 64'(bus.acc_clr), 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_done"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int cyc, nval, d0;
        model_clear();
        rst_n = 0;
        quiet();
        for (int r = 0; r < 6; r++) begin
            @(negedge clk);
            bus.wr_en = 1'($urandom); bus.wr_mat = 1'($urandom); bus.wr_idx = 3'($urandom);
            bus.wr_data = 32'($urandom); bus.start = 1'($urandom); bus.abort = 1'($urandom);
        end
        @(negedge clk);
        chk_zero_outs("rst_hold");
        rst_n = 1;
        quiet();

        start_pulse();
        wait_done(cyc, nval);
        chk("zero_run_done_c", 64'(cyc), 64'd15);

        load_ab();
        start_pulse();
        chk("nom_c0_a", 64'(bus.a_out), 64'h0);
        chk("nom_c0_clr", 64'(bus.acc_clr), 64'd1);
        repeat (3) @(negedge clk);
        chk("nom_c3_a", 64'(bus.a_out), 64'h30211203);
        repeat (4) @(negedge clk);
        chk("nom_c7_b0", 64'(bus.b_out[7:0]), 64'h70);
        repeat (3) @(negedge clk);
        chk("nom_c10_a", 64'(bus.a_out), 64'h37000000);
        chk("nom_c10_b", 64'(bus.b_out), 64'h73000000);
        wait_done(cyc, nval);
        chk("nom_done_c", 64'(cyc + 10), 64'd15);
        chk("nom_valid_cnt", 64'(nval + 10), 64'd11);
        chk("nom_busy_at_done", 64'(bus.busy), 64'd0);

        start_pulse();
        repeat (4) @(negedge clk);
        bus.start = 1; bus.wr_en = 1; bus.wr_mat = 0; bus.wr_idx = '0; bus.wr_data = 32'h302010FF;
        d0 = n_done;
        @(negedge clk);
        quiet();
        wait_done(cyc, nval);
        chk("busy_done_c", 64'(cyc + 5), 64'd15);
        repeat (4) @(negedge clk);
        chk("busy_one_done", 64'(n_done - d0), 64'd1);
        start_pulse();
        chk("busy_a00", 64'(bus.a_out), 64'h0);
        wait_done(cyc, nval);

        @(negedge clk); bus.start = 1;
        @(negedge clk);
        wait_done(cyc, nval);
        chk("b2b_first_c", 64'(cyc), 64'd15);
        @(negedge clk);
        bus.start = 0;
        chk("b2b_clr", 64'(bus.acc_clr), 64'd1);
        chk("b2b_valid", 64'(bus.out_valid), 64'd1);
        repeat (3) @(negedge clk);
        chk("b2b_c3_a", 64'(bus.a_out), 64'h30211203);
        wait_done(cyc, nval);
        chk("b2b_second_c", 64'(cyc + 3), 64'd15);

        start_pulse();
        repeat (5) @(negedge clk);
        bus.abort = 1;
        @(negedge clk);
        bus.abort = 0;
        chk_zero_outs("abort");
        d0 = n_done;
        repeat (20) @(negedge clk);
        chk("abort_no_done", 64'(n_done - d0), 64'd0);
        start_pulse();
        wait_done(cyc, nval);
        chk("abort_rerun_c", 64'(cyc), 64'd15);
        chk("abort_rerun_valid", 64'(nval), 64'd11);

        start_pulse();
        repeat (6) @(negedge clk);
        #2 rst_n = 0;
        #1 chk_zero_outs("midrst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        start_pulse();
        wait_done(cyc, nval);
        chk("midrst_done_c", 64'(cyc), 64'd15);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
